// File: rtl/session_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// session_ctrl_fsm
//   Multiplayer session controller between game logic, the per-opponent
//   receivers and the handshake senders. It tracks the ACKs and
//   eliminations of NUM_OPP opponents, applies the ready/lost/win
//   timeouts and reports the final placement.
//
// Ports
//   clk             clock
//   rst_l           asynchronous active-low reset
//   player_ready    player requests a game (sampled in IDLE only)
//   player_unready  player cancels (sampled in GAME_READY only)
//   top_out         local player lost (sampled in IN_GAME only)
//   ack_received    per-opponent ACK seen by the receiver
//   opp_game_end    per-opponent "opponent lost" from the receiver
//   send_ready      drive ACK on the handshake lines
//   send_game_lost  drive GAME END on the handshake lines
//   game_active     high in every state except IDLE
//   idle/gameready/ingame/gamelost/gamewon  one-hot state flags
//   opp_alive       opponents not yet eliminated in the current game
//   placement       final rank, 1 = winner, 0 = no result
//   ready_abort     one-cycle pulse when GAME_READY times out
//
// All outputs are registered. They are decoded from the next state, so
// each flag changes in the same cycle as the state register.
//
// state      | meaning
// S_IDLE     | no session, last placement still visible
// S_READY    | sending ACK, collecting ACKs from every opponent
// S_INGAME   | game running, tracking opponent eliminations
// S_LOST     | local loss, sending GAME END until alive opponents ACK
// S_WON      | all opponents out, sending ACK for the win hold time
// ---------------------------------------------------------------------------
module session_ctrl_fsm #(
  parameter int unsigned NUM_OPP              = 1,
  parameter int unsigned READY_TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned LOST_TIMEOUT_CYCLES  = 25_000_000,
  parameter int unsigned WIN_TIMEOUT_CYCLES   = 25_000_000,
  localparam int unsigned PL_W = $clog2(NUM_OPP + 2)
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               player_ready,
  input  logic               player_unready,
  input  logic               top_out,
  input  logic [NUM_OPP-1:0] ack_received,
  input  logic [NUM_OPP-1:0] opp_game_end,
  output logic               send_ready,
  output logic               send_game_lost,
  output logic               game_active,
  output logic               idle,
  output logic               gameready,
  output logic               ingame,
  output logic               gamelost,
  output logic               gamewon,
  output logic [NUM_OPP-1:0] opp_alive,
  output logic [PL_W-1:0]    placement,
  output logic               ready_abort
);

  localparam int unsigned MAX_RL = (READY_TIMEOUT_CYCLES > LOST_TIMEOUT_CYCLES) ?
                                   READY_TIMEOUT_CYCLES : LOST_TIMEOUT_CYCLES;
  localparam int unsigned MAX_TO = (MAX_RL > WIN_TIMEOUT_CYCLES) ? MAX_RL : WIN_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_TO + 1);

  // Terminal counts; a zero timeout is mapped to 0 and gated by its enable.
  localparam logic [CNT_W-1:0] READY_LAST = (READY_TIMEOUT_CYCLES == 0) ? '0 :
                                            CNT_W'(READY_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOST_LAST  = (LOST_TIMEOUT_CYCLES == 0) ? '0 :
                                            CNT_W'(LOST_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = (WIN_TIMEOUT_CYCLES == 0) ? '0 :
                                            CNT_W'(WIN_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_INGAME = 3'd2,
    S_LOST   = 3'd3,
    S_WON    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OPP-1:0] ack_mask_q, ack_mask_d;
  logic [NUM_OPP-1:0] opp_alive_q, opp_alive_d;
  logic [PL_W-1:0]    placement_q, placement_d;
  logic               ready_abort_q, ready_abort_d;
  logic               send_ready_q, send_game_lost_q, game_active_q;
  logic               idle_q, gameready_q, ingame_q, gamelost_q, gamewon_q;

  logic [NUM_OPP-1:0] acks_seen;
  logic [NUM_OPP-1:0] alive_next;

  function automatic logic [PL_W-1:0] popcount(input logic [NUM_OPP-1:0] v);
    logic [PL_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OPP; i++) n = n + PL_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    state_d       = state_q;
    opp_alive_d   = opp_alive_q;
    placement_d   = placement_q;
    ready_abort_d = 1'b0;
    acks_seen     = ack_mask_q | ack_received;
    alive_next    = opp_alive_q & ~opp_game_end;

    case (state_q)
      S_IDLE: begin
        if (player_ready) begin
          state_d     = S_READY;
          placement_d = '0;
        end
      end
      S_READY: begin
        if (player_unready) begin
          state_d = S_IDLE;
        end else if (&acks_seen) begin
          state_d     = S_INGAME;
          opp_alive_d = '1;
        end else if ((READY_TIMEOUT_CYCLES != 0) && (cnt_q == READY_LAST)) begin
          state_d       = S_IDLE;
          ready_abort_d = 1'b1;
        end
      end
      S_INGAME: begin
        opp_alive_d = alive_next;
        // Last elimination beats a simultaneous local loss.
        if (alive_next == '0) begin
          state_d     = S_WON;
          placement_d = PL_W'(1);
        end else if (top_out) begin
          state_d     = S_LOST;
          placement_d = popcount(alive_next) + PL_W'(1);
        end
      end
      S_LOST: begin
        // Only opponents still alive at the loss have to acknowledge.
        if (((acks_seen & opp_alive_q) == opp_alive_q) ||
            ((LOST_TIMEOUT_CYCLES != 0) && (cnt_q == LOST_LAST))) begin
          state_d = S_IDLE;
        end
      end
      S_WON: begin
        if (cnt_q == WIN_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d      = '0;
      ack_mask_d = '0;
    end else begin
      cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      ack_mask_d = acks_seen;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      ack_mask_q       <= '0;
      opp_alive_q      <= '0;
      placement_q      <= '0;
      ready_abort_q    <= 1'b0;
      send_ready_q     <= 1'b0;
      send_game_lost_q <= 1'b0;
      game_active_q    <= 1'b0;
      idle_q           <= 1'b1;
      gameready_q      <= 1'b0;
      ingame_q         <= 1'b0;
      gamelost_q       <= 1'b0;
      gamewon_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      ack_mask_q       <= ack_mask_d;
      opp_alive_q      <= opp_alive_d;
      placement_q      <= placement_d;
      ready_abort_q    <= ready_abort_d;
      send_ready_q     <= (state_d == S_READY) || (state_d == S_WON);
      send_game_lost_q <= (state_d == S_LOST);
      game_active_q    <= (state_d != S_IDLE);
      idle_q           <= (state_d == S_IDLE);
      gameready_q      <= (state_d == S_READY);
      ingame_q         <= (state_d == S_INGAME);
      gamelost_q       <= (state_d == S_LOST);
      gamewon_q        <= (state_d == S_WON);
    end
  end

  assign send_ready     = send_ready_q;
  assign send_game_lost = send_game_lost_q;
  assign game_active    = game_active_q;
  assign idle           = idle_q;
  assign gameready      = gameready_q;
  assign ingame         = ingame_q;
  assign gamelost       = gamelost_q;
  assign gamewon        = gamewon_q;
  assign opp_alive      = opp_alive_q;
  assign placement      = placement_q;
  assign ready_abort    = ready_abort_q;

endmodule

// File: doc/session_ctrl_fsm.md
Name: session_ctrl_fsm

Overview:
- Parametrised multiplayer session controller for the networking layer. Sits between game logic, the per-opponent receivers and the handshake senders.
- Generalises the single-opponent sender FSM to NUM_OPP opponents.
- Adds internal timeouts (ready abort, lost give-up, win hold), per-opponent sticky ACK/elimination tracking and final placement reporting.

Parameters:
- NUM_OPP, 1, number of opponents (1..7).
- READY_TIMEOUT_CYCLES, 50_000_000, max cycles in GAME_READY before abort; 0 disables abort.
- LOST_TIMEOUT_CYCLES, 25_000_000, max cycles in GAME_LOST waiting for ACKs.
- WIN_TIMEOUT_CYCLES, 25_000_000, cycles held in GAME_WON before IDLE (must be >=1).

Ports:
- clk  in  1  GPIO clock
- rst_l  in  1  asynchronous active-low reset
- player_ready  in  1  player requests multiplayer game
- player_unready  in  1  player cancels while in GAME_READY
- top_out  in  1  local player lost, from game logic
- ack_received  in  NUM_OPP  per-opponent ACK seen by receiver
- opp_game_end  in  NUM_OPP  per-opponent "opponent lost" from receiver
- send_ready  out  1  drive ACK on handshake lines
- send_game_lost  out  1  drive GAME END on handshake lines
- game_active  out  1  high in every state except IDLE
- idle, gameready, ingame, gamelost, gamewon  out  1 each  one-hot state flags
- opp_alive  out  NUM_OPP  opponents not yet eliminated in current game
- placement  out  $clog2(NUM_OPP+2)  final rank; 1 = winner, 0 = no result
- ready_abort  out  1  one-cycle pulse on GAME_READY timeout exit

Behaviour:
- Reset (async, rst_l low): state IDLE; idle=1; all other outputs 0. ack_mask, opp_alive, placement and counter are cleared.
- All outputs are registered state decodes or registered values. No combinational path from inputs to outputs.
- Single counter, width $clog2(max timeout+1). It clears on every state change and increments every cycle otherwise, saturating at all-ones.
- ack_mask (NUM_OPP): clears on every state change. Otherwise it is set bitwise by ack_received (OR-accumulate).

IDLE:
- Outputs: send_ready=0, send_game_lost=0.
- player_ready -> GAME_READY.
- placement keeps the last result until the next GAME_READY entry, then clears to 0.

GAME_READY:
- Outputs: send_ready=1.
- Priority 1: player_unready -> IDLE.
- Priority 2: (ack_mask | ack_received) all-ones -> IN_GAME. Sets opp_alive to all-ones on entry.
- Priority 3: READY_TIMEOUT_CYCLES!=0 and counter==READY_TIMEOUT_CYCLES-1 -> IDLE, with ready_abort=1 for exactly one cycle.

IN_GAME:
- Outputs: send_ready=0.
- Each cycle: opp_alive <= opp_alive & ~opp_game_end. Bits never re-set until the next game.
- Priority 1: (opp_alive & ~opp_game_end)==0 -> GAME_WON, placement=1. This wins over a simultaneous top_out.
- Priority 2: top_out -> GAME_LOST. placement = popcount(opp_alive & ~opp_game_end)+1, i.e. eliminations arriving in the same cycle count before the local loss.

GAME_LOST:
- Outputs: send_game_lost=1.
- Exit to IDLE when either condition holds:
  - ((ack_mask | ack_received) & opp_alive) == opp_alive, ACKs required only from opponents still alive at loss; or
  - counter==LOST_TIMEOUT_CYCLES-1.
- opp_alive is frozen in this state.

GAME_WON:
- Outputs: send_ready=1.
- counter==WIN_TIMEOUT_CYCLES-1 -> IDLE.
- All inputs ignored.

Common rules:
- game_active=1 in GAME_READY, IN_GAME, GAME_LOST, GAME_WON.
- ready_abort is 0 in all cases except the abort exit cycle.
- player_unready outside GAME_READY, and player_ready outside IDLE, are ignored.
- Reset asserted mid-game returns to IDLE immediately with all outputs at reset values. No handshake is emitted.

Test Plan:
- NUM_OPP=3, READY_TIMEOUT=20: player_ready, then ack_received = 001 (cycle 2), 100 (cycle 5), 010 (cycle 7) -> ingame=1 at cycle 8, opp_alive=111, send_ready=0.
- GAME_READY, opponent 1 never ACKs -> exactly 20 cycles in GAME_READY, ready_abort pulses 1 cycle, idle=1; repeat with player_unready at cycle 4 -> idle next cycle, no abort pulse.
- IN_GAME, NUM_OPP=3: opp_game_end=010, then 100; top_out in the same cycle as opp_game_end=001 -> GAME_WON, placement=1, send_ready=1 held for WIN_TIMEOUT cycles, then idle.
- IN_GAME: opp_game_end=100, then top_out -> GAME_LOST, placement=3, send_game_lost=1; ack 001 then 010 -> IDLE; an ACK from eliminated opponent 2 is not required.
- GAME_LOST with no ACKs, LOST_TIMEOUT=10 -> IDLE after exactly 10 cycles; placement retained in IDLE, cleared on next player_ready.
- Assert rst_l low in each of the 5 states -> next sampled outputs idle=1, all others 0, opp_alive=0, placement=0.
